// File: rtl/tcon_rx_buffer.sv
// Receive buffer: registers each accepted load word as the held value and queues it for a downstream valid/ready consumer.
// Latency: a word pushed at edge N is at the FIFO head after edge N and can be popped at edge N+1; there is no bypass.
// Backpressure: accept_o drops only when the FIFO is full; a load refused then is dropped and sets the sticky ovf_o.
module tcon_rx_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             accept_o,
    output logic [WIDTH-1:0] held_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [CW-1:0]    count_o,
    output logic             ovf_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] held;
    logic             ovf;
    logic             push;
    logic             pop;

    // Full/empty come from the occupancy count, so pointers may wrap freely.
    assign accept_o    = (count != CW'(DEPTH));
    assign out_valid_o = (count != '0);
    assign out_data_o  = mem[rptr];
    assign held_o      = held;
    assign count_o     = count;
    assign ovf_o       = ovf;

    assign push = load_i & accept_o;
    assign pop  = out_valid_o & out_ready_i;

    // Storage is not cleared by reset; writes are suppressed in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            held  <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
                held <= data_i;
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (load_i && !accept_o) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
